// File: rtl/partial_load_unit_pkg.sv
// Shared constants and types for the load alignment path between MEM and WB.
// Opcode/funct3 encodings follow the RV32I base ISA.
package partial_load_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] FNC_LB  = 3'd0;
    localparam logic [2:0] FNC_LH  = 3'd1;
    localparam logic [2:0] FNC_LW  = 3'd2;
    localparam logic [2:0] FNC_LBU = 3'd4;
    localparam logic [2:0] FNC_LHU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LIVE = 2'd1,
        ST_HELD = 2'd2
    } state_e;

endpackage

// File: rtl/partial_load_unit_if.sv
// MEM-stage request / memory return / WB-side result bundle.
// master drives requests and memory data; slave is the load unit.
interface partial_load_unit_if;
    import partial_load_unit_pkg::*;

    logic            req_valid;
    logic [31:0]     instruction;
    logic [XLEN-1:0] mem_addr;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] mem_dout;
    logic [XLEN-1:0] load_data;
    logic            load_valid;
    logic [4:0]      load_rd;
    logic            misaligned;

    modport master (
        output req_valid, instruction, mem_addr, stall, flush, mem_dout,
        input  load_data, load_valid, load_rd, misaligned
    );

    modport slave (
        input  req_valid, instruction, mem_addr, stall, flush, mem_dout,
        output load_data, load_valid, load_rd, misaligned
    );

endinterface

// File: rtl/partial_load_unit_load_extract.sv
// Byte/halfword/word selection with sign or zero extension and natural-alignment check.
// Purely combinational; unsupported funct3 values yield zero without a misaligned flag.
module load_extract
    import partial_load_unit_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] word_i,
    output logic [XLEN-1:0] data_o,
    output logic            misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o       = '0;
        misaligned_o = 1'b0;
        case (funct3_i)
            FNC_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            FNC_LBU: data_o = {24'h0, byte_sel};
            FNC_LH: begin
                if (off_i[0]) misaligned_o = 1'b1;
                else          data_o = {{16{half_sel[15]}}, half_sel};
            end
            FNC_LHU: begin
                if (off_i[0]) misaligned_o = 1'b1;
                else          data_o = {16'h0, half_sel};
            end
            FNC_LW: begin
                if (off_i != 2'd0) misaligned_o = 1'b1;
                else               data_o = word_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/partial_load_unit.sv
// Captures a load at MEM issue and presents the aligned result one cycle later,
// holding the memory word across stalls so the result stays stable.
//
//   state | meaning
//   IDLE  | no live load; all outputs zero
//   LIVE  | load issued last edge; extract from mem_dout directly
//   HELD  | stalled after issue; extract from hold_q
module partial_load_unit
    import partial_load_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    partial_load_unit_if.slave   bus
);

    state_e          state_q;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] hold_q;

    logic            is_load;
    logic            live;
    logic [XLEN-1:0] word_sel;
    logic [XLEN-1:0] ext_data;
    logic            ext_mis;
    logic            unused_bits;

    assign is_load     = bus.req_valid && (bus.instruction[6:0] == OPC_LOAD);
    assign unused_bits = ^{bus.instruction[31:15], bus.mem_addr[XLEN-1:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            rd_q     <= 5'd0;
            hold_q   <= '0;
        end else if (bus.flush) begin
            state_q <= ST_IDLE;
        end else if (bus.stall) begin
            // First stall edge after issue snapshots the returning word.
            if (state_q == ST_LIVE) begin
                hold_q  <= bus.mem_dout;
                state_q <= ST_HELD;
            end
        end else if (is_load) begin
            funct3_q <= bus.instruction[14:12];
            off_q    <= bus.mem_addr[1:0];
            rd_q     <= bus.instruction[11:7];
            state_q  <= ST_LIVE;
        end else begin
            state_q <= ST_IDLE;
        end
    end

    assign live     = (state_q != ST_IDLE);
    assign word_sel = (state_q == ST_HELD) ? hold_q : bus.mem_dout;

    load_extract u_extract (
        .funct3_i     (funct3_q),
        .off_i        (off_q),
        .word_i       (word_sel),
        .data_o       (ext_data),
        .misaligned_o (ext_mis)
    );

    assign bus.load_valid = live;
    assign bus.load_data  = live ? ext_data : '0;
    assign bus.load_rd    = live ? rd_q : 5'd0;
    assign bus.misaligned = live && ext_mis;

endmodule
